// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle controller: state enum,
// ALU operation codes, datapath select constants and data-processing cmd codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields and memory handshake in, datapath controls and debug
// state out. Memory handshake: mem_ready=1 in a cycle means the access
// presented in that cycle completed; the controller holds its state until then.
interface mc_controller_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       mem_ready;

  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic       RegW;
  logic       MemW;
  logic       PCS;
  logic       illegal;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    output Op, Funct, Rd, mem_ready,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           FlagW, RegW, MemW, PCS, illegal, instr_done, state
  );

  modport slave (
    input  Op, Funct, Rd, mem_ready,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           FlagW, RegW, MemW, PCS, illegal, instr_done, state
  );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the data-processing cmd field to an ALU operation and
// flag-write enables while ALUOp is set; all zero otherwise.
module aludec
  import mc_pkg::*;
(
  input  logic       ALUOp,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       illegal_cmd
);

  logic       arith;
  logic [3:0] cmd;
  logic       unused_funct_i;

  assign cmd            = Funct[4:1];
  assign unused_funct_i = Funct[5];

  always_comb begin
    ALUControl  = ALU_ADD;
    FlagW       = 2'b00;
    illegal_cmd = 1'b0;
    arith       = 1'b0;
    if (ALUOp) begin
      case (cmd)
        CMD_ADD: begin ALUControl = ALU_ADD; arith = 1'b1; end
        CMD_SUB: begin ALUControl = ALU_SUB; arith = 1'b1; end
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: illegal_cmd = 1'b1;
      endcase
      // Unsupported commands leave flags untouched.
      if (!illegal_cmd) begin
        FlagW[1] = Funct[0];
        FlagW[0] = Funct[0] & arith;
      end
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle controller FSM: sequences fetch/decode/memory/execute/writeback
// and decodes datapath controls from the current state.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit MEM_HS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mc_controller_if.slave    bus
);

  state_e     state_q, state_d;
  state_e     dec_state;
  logic       ready;
  logic       alu_op;
  logic [1:0] alu_ctrl;
  logic [1:0] flag_w;
  logic       illegal_cmd;
  logic       illegal_fsm;
  logic       reg_w;
  logic       pcs_br;

  assign ready = MEM_HS ? bus.mem_ready : 1'b1;
  // While reset is held low every output shows the FETCH decode.
  assign dec_state = reset ? state_q : S_FETCH;
  assign alu_op    = (dec_state == S_EXECR) || (dec_state == S_EXECI);

  aludec u_aludec (
    .ALUOp       (alu_op),
    .Funct       (bus.Funct),
    .ALUControl  (alu_ctrl),
    .FlagW       (flag_w),
    .illegal_cmd (illegal_cmd)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = S_FETCH;
    bus.IRWrite    = 1'b0;
    bus.NextPC     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_REG;
    bus.ResultSrc  = RES_ALUOUT;
    bus.MemW       = 1'b0;
    bus.instr_done = 1'b0;
    reg_w          = 1'b0;
    pcs_br         = 1'b0;
    illegal_fsm    = 1'b0;
    case (dec_state)
      S_FETCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        if (ready) begin
          bus.IRWrite = reset;
          bus.NextPC  = 1'b1;
          state_d     = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            state_d        = S_FETCH;
            illegal_fsm    = 1'b1;
            bus.instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcB = SRCB_IMM;
        state_d     = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.AdrSrc = 1'b1;
        state_d    = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.ResultSrc  = RES_RDATA;
        reg_w          = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc     = 1'b1;
        bus.MemW       = 1'b1;
        bus.instr_done = ready;
        state_d        = ready ? S_FETCH : S_MEMWR;
      end
      S_EXECR: state_d = S_ALUWB;
      S_EXECI: begin
        bus.ALUSrcB = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w          = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ResultSrc  = RES_ALU;
        pcs_br         = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.RegW       = reg_w;
  assign bus.PCS        = pcs_br | (reg_w & (bus.Rd == 4'd15));
  assign bus.ALUControl = alu_ctrl;
  assign bus.FlagW      = flag_w;
  assign bus.illegal    = illegal_fsm | illegal_cmd;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the
// FSM and compares states and control outputs against hand-computed values.
module tb_mc_controller;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_q[$];

  mc_controller_if bus ();

  mc_controller #(.MEM_HS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic rdy);
    bus.Op        = op;
    bus.Funct     = funct;
    bus.Rd        = rd;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic chk_state(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: expected-state queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {28'd0, bus.state}, {28'd0, e});
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Data-processing instruction from FETCH back to FETCH, mem_ready=1.
  task automatic run_dp(input string tag, input logic [5:0] funct, input logic [3:0] rd,
                        input logic [1:0] e_alu, input logic [1:0] e_flag,
                        input logic e_ill, input logic e_pcs);
    exp_q = {4'd0, 4'd1, (funct[5] ? 4'd7 : 4'd6), 4'd8, 4'd0};
    drive(2'b00, funct, rd, 1'b1);
    chk_state({tag, "_s0"});
    tick();
    chk_state({tag, "_s1"});
    tick();
    chk_state({tag, "_s2"});
    check({tag, "_alu"}, {30'd0, bus.ALUControl}, {30'd0, e_alu});
    check({tag, "_flagw"}, {30'd0, bus.FlagW}, {30'd0, e_flag});
    check({tag, "_illegal"}, {31'd0, bus.illegal}, {31'd0, e_ill});
    check({tag, "_regw_exec"}, {31'd0, bus.RegW}, 32'd0);
    tick();
    chk_state({tag, "_s3"});
    check({tag, "_regw_wb"}, {31'd0, bus.RegW}, 32'd1);
    check({tag, "_pcs_wb"}, {31'd0, bus.PCS}, {31'd0, e_pcs});
    check({tag, "_done_wb"}, {31'd0, bus.instr_done}, 32'd1);
    check({tag, "_alu_wb"}, {30'd0, bus.ALUControl}, 32'd0);
    tick();
    chk_state({tag, "_s4"});
  endtask

  initial begin
    int n;
    int hold;
    int stalls;

    reset = 1'b0;
    bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.mem_ready = 1'b0;
    repeat (2) tick();
    check("rst_state", {28'd0, bus.state}, 32'd0);
    check("rst_irwrite", {31'd0, bus.IRWrite}, 32'd0);
    check("rst_nextpc", {31'd0, bus.NextPC}, 32'd0);
    check("rst_regw", {31'd0, bus.RegW}, 32'd0);
    check("rst_memw", {31'd0, bus.MemW}, 32'd0);
    check("rst_srcb", {30'd0, bus.ALUSrcB}, 32'd2);
    reset = 1'b1;
    tick();
    check("fetch_hold", {28'd0, bus.state}, 32'd0);
    check("fetch_hold_ir", {31'd0, bus.IRWrite}, 32'd0);

    // ADD immediate, S=0
    drive(2'b00, 6'b101000, 4'd1, 1'b1);
    check("add_irwrite", {31'd0, bus.IRWrite}, 32'd1);
    check("add_nextpc", {31'd0, bus.NextPC}, 32'd1);
    run_dp("addi", 6'b101000, 4'd1, ALU_ADD, 2'b00, 1'b0, 1'b0);
    // SUBS register, then with Rd=15
    run_dp("subs", 6'b000101, 4'd2, ALU_SUB, 2'b11, 1'b0, 1'b0);
    run_dp("subs_pc", 6'b000101, 4'd15, ALU_SUB, 2'b11, 1'b0, 1'b1);
    run_dp("ands", 6'b000001, 4'd3, ALU_AND, 2'b10, 1'b0, 1'b0);
    run_dp("orri", 6'b111000, 4'd4, ALU_ORR, 2'b00, 1'b0, 1'b0);
    run_dp("badcmd", 6'b000011, 4'd5, ALU_ADD, 2'b00, 1'b1, 1'b0);

    // LDR with two wait cycles in MEMRD
    drive(2'b01, 6'b000001, 4'd6, 1'b1);
    n = 0; hold = 0; stalls = 0;
    while (n < 20 && !(n > 0 && bus.state == 4'd0)) begin
      if (bus.state == 4'd3 && stalls < 2) begin
        bus.mem_ready = 1'b0;
        stalls++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      if (bus.state == 4'd3) begin
        hold++;
        check("ldr_memrd_adr", {31'd0, bus.AdrSrc}, 32'd1);
      end
      if (bus.state == 4'd2)
        check("ldr_memadr_srcb", {30'd0, bus.ALUSrcB}, 32'd1);
      if (bus.state == 4'd4) begin
        check("ldr_wb_regw", {31'd0, bus.RegW}, 32'd1);
        check("ldr_wb_res", {30'd0, bus.ResultSrc}, 32'd1);
      end
      tick();
      n++;
    end
    check("ldr_cycles", n, 32'd7);
    check("ldr_memrd_hold", hold, 32'd3);

    // Branch
    exp_q = {4'd0, 4'd1, 4'd9, 4'd0};
    drive(2'b10, 6'b000000, 4'd0, 1'b1);
    chk_state("br_s0");
    tick();
    chk_state("br_s1");
    tick();
    chk_state("br_s2");
    check("br_pcs", {31'd0, bus.PCS}, 32'd1);
    check("br_done", {31'd0, bus.instr_done}, 32'd1);
    check("br_regw", {31'd0, bus.RegW}, 32'd0);
    tick();
    chk_state("br_s3");

    // STR, reset on the second MEMWR wait cycle
    exp_q = {4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0, 4'd0};
    drive(2'b01, 6'b000000, 4'd7, 1'b1);
    chk_state("str_s0");
    tick();
    chk_state("str_s1");
    tick();
    chk_state("str_s2");
    tick();
    drive(2'b01, 6'b000000, 4'd7, 1'b0);
    chk_state("str_w1");
    check("str_w1_memw", {31'd0, bus.MemW}, 32'd1);
    check("str_w1_done", {31'd0, bus.instr_done}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk_state("str_w2");
    check("str_rst_memw", {31'd0, bus.MemW}, 32'd0);
    check("str_rst_done", {31'd0, bus.instr_done}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk_state("str_after_rst");
    check("str_after_ir", {31'd0, bus.IRWrite}, 32'd0);
    tick();
    chk_state("str_after_hold");
    check("str_hold_ir", {31'd0, bus.IRWrite}, 32'd0);
    drive(2'b01, 6'b000000, 4'd7, 1'b1);
    check("str_ready_ir", {31'd0, bus.IRWrite}, 32'd1);
    do_reset();

    // Op=11 illegal
    drive(2'b11, 6'b000000, 4'd8, 1'b1);
    tick();
    check("ill_state", {28'd0, bus.state}, 32'd1);
    check("ill_illegal", {31'd0, bus.illegal}, 32'd1);
    check("ill_done", {31'd0, bus.instr_done}, 32'd1);
    check("ill_regw", {31'd0, bus.RegW}, 32'd0);
    check("ill_memw", {31'd0, bus.MemW}, 32'd0);
    tick();
    check("ill_next", {28'd0, bus.state}, 32'd0);
    check("ill_clear", {31'd0, bus.illegal}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: MEM_HS, default 1, meaning: 1 = FETCH/MEMRD/MEMWR wait on mem_ready; 0 = mem_ready treated as constant 1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (reset=0 sampled at clk edge resets the block).
REQ-004 Op  input  2  instruction bits [27:26].
REQ-005 Funct  input  6  instruction bits [25:20]: Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S or L.
REQ-006 Rd  input  4  destination register field.
REQ-007 mem_ready  input  1  memory access complete this cycle.
REQ-008 IRWrite  output  1  load instruction register.
REQ-009 NextPC  output  1  unconditional PC update (PC+4).
REQ-010 AdrSrc  output  1  0 = PC, 1 = ALU result as memory address.
REQ-011 ALUSrcA  output  1  0 = register A, 1 = PC.
REQ-012 ALUSrcB  output  2  00 = register B, 01 = extended immediate, 10 = constant 4.
REQ-013 ResultSrc  output  2  00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-014 ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-015 FlagW  output  2  [1] = N,Z write; [0] = C,V write; pre-condition (gated by CondEx downstream).
REQ-016 RegW, MemW, PCS  output  1 each  pre-condition write/branch requests to condition logic.
REQ-017 illegal  output  1  one-cycle pulse on unsupported Op or cmd.
REQ-018 instr_done  output  1  one-cycle pulse in the final state of every instruction.
REQ-019 state  output  4  current state encoding, for debug.

Function
REQ-020 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; encodings 10-15 SHALL return to FETCH next cycle.
REQ-021 Transitions:
- FETCH->DECODE when mem_ready, else hold.
- DECODE by Op: 01->MEMADR; 00 with Funct[5]=0->EXECR; 00 with Funct[5]=1->EXECI; 10->BRANCH; 11->FETCH with illegal=1.
- MEMADR: Funct[0]=1->MEMRD, else MEMWR.
- MEMRD->MEMWB when mem_ready, else hold.
- MEMWR->FETCH when mem_ready, else hold.
- EXECR, EXECI->ALUWB.
- MEMWB, ALUWB, BRANCH->FETCH.
REQ-022 Outputs are Moore-decoded from state, except the cases in REQ-023 and REQ-024; every unlisted output is 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1 for every cycle spent in the state.
- EXECR: ALUSrcB=00, ALU decode.
- EXECI: ALUSrcB=01, ALU decode.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCS=1.
REQ-023 IRWrite and NextPC SHALL assert only in the FETCH cycle where mem_ready=1.
REQ-024 PCS SHALL also assert when RegW=1 and Rd=15.
REQ-025 ALU decode (EXECR/EXECI only), by cmd:
- 0100 -> ADD; 0010 -> SUB; 0000 -> AND; 1100 -> ORR.
- FlagW[1] = Funct[0].
- FlagW[0] = Funct[0] and (ADD or SUB).
- Other cmd: ALUControl=00, FlagW=00, illegal=1 that cycle; ALUWB still executes.
REQ-026 ALUControl=00 and FlagW=00 in all other states.
REQ-027 instr_done SHALL assert in MEMWB, ALUWB, BRANCH, the MEMWR exit cycle (mem_ready=1), and DECODE with Op=11.
REQ-028 Latency with mem_ready=1: data-processing 4 cycles; LDR 5; STR 4; branch 3. Each wait cycle adds exactly 1.
REQ-029 Inputs are sampled combinationally each cycle; the block holds no instruction copy (the IR is external).

Reset
REQ-030 reset=0 at an edge SHALL force state=FETCH regardless of current state or pending wait, including mid-MEMWR.
REQ-031 During and after reset, all outputs take their FETCH-state values: IRWrite=0, NextPC=0 unless mem_ready=1, RegW=MemW=PCS=illegal=instr_done=0.

Structure
REQ-032 Package mc_pkg SHALL hold the state enum, the ALUControl codes, and the ALUSrcB and ResultSrc select constants.
REQ-033 One sub-module, aludec, SHALL implement REQ-025 and REQ-026, with inputs ALUOp, Funct and outputs ALUControl, FlagW, illegal_cmd.

Verification
REQ-034 Scenario ADD immediate (Op=00, Funct=101000), mem_ready=1:
- state sequence 0,1,7,8,0;
- RegW=1 only in ALUWB;
- ALUControl=00 and FlagW=00 in EXECI.
REQ-035 Scenario LDR (Op=01, Funct[0]=1), mem_ready low 2 cycles in MEMRD:
- 7 cycles total;
- state held at 3 for 3 cycles;
- RegW=1 and ResultSrc=01 in MEMWB.
REQ-036 Scenario SUBS (cmd=0010, S=1):
- FlagW=11 and ALUControl=01 in EXECR.
- Same instruction with Rd=15: PCS=1 in ALUWB.
REQ-037 Scenario branch (Op=10):
- sequence 0,1,9,0;
- PCS=1 and instr_done=1 in BRANCH.
REQ-038 Scenario STR with reset=0 asserted on the 2nd MEMWR wait cycle:
- next state=0;
- MemW=0 that cycle;
- IRWrite=0 until mem_ready.
REQ-039 Scenario Op=11:
- illegal=1 and instr_done=1 in DECODE;
- next state=0;
- no RegW/MemW.
